// File: rtl/sram_phase_scheduler_pkg.sv
// Shared definitions for the decode-flow sequencer: phase encodings used by the
// top-level SRAM muxing and by LED/debug logic elsewhere in the project.
package sram_phase_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_UART_RX = 3'd1,
    S_GAP_M2  = 3'd2,
    S_M2      = 3'd3,
    S_GAP_M1  = 3'd4,
    S_M1      = 3'd5
  } top_state_type;

  localparam int PHASE_W = 3;

  // True in the states where a phase unit owns the SRAM and the watchdog runs.
  function automatic logic is_unit_phase(top_state_type s);
    return (s == S_M2) || (s == S_M1);
  endfunction

endpackage

// File: rtl/sram_phase_scheduler_phase_timer.sv
// Up-counter with same-cycle clear and an equality terminal-count flag; used for the
// UART idle timeout and for the per-phase watchdog.
module sram_phase_scheduler_phase_timer #(
  parameter int TERMINAL = 19
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int W = (TERMINAL < 1) ? 1 : $clog2(TERMINAL + 1);
  localparam logic [W-1:0] TC_VAL = W'(TERMINAL);

  logic [W-1:0] count_reg;
  logic [W-1:0] count_now;

  // A clear takes effect in the cycle it is asserted, so that cycle counts as zero.
  assign count_now = clear ? '0 : count_reg;
  assign tc        = enable && (count_now == TC_VAL);

  always_ff @(posedge clk) begin
    if (srst) begin
      count_reg <= '0;
    end else if (enable && !tc) begin
      count_reg <= count_now + W'(1);
    end else begin
      count_reg <= count_now;
    end
  end

endmodule

// File: rtl/sram_phase_scheduler.sv
// Decode-flow sequencer (IDLE -> UART RX -> M2 -> M1 -> IDLE) and sole owner of the
// external SRAM port; grants it to one requester per state with a dead gap between phases.
module sram_phase_scheduler
  import sram_phase_scheduler_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int DATA_W       = 16,
  parameter int UART_TIMEOUT = 50_000_000,
  parameter int WDOG_CYCLES  = 2**24
) (
  input  logic              CLOCK_50_I,
  input  logic              Reset,
  input  logic              UART_RX_I,
  input  logic [ADDR_W-1:0] UART_SRAM_address,
  input  logic [DATA_W-1:0] UART_SRAM_wdata,
  input  logic              UART_SRAM_we_n,
  input  logic [ADDR_W-1:0] M2_SRAM_address,
  input  logic [DATA_W-1:0] M2_SRAM_wdata,
  input  logic              M2_SRAM_we_n,
  input  logic [ADDR_W-1:0] M1_SRAM_address,
  input  logic [DATA_W-1:0] M1_SRAM_wdata,
  input  logic              M1_SRAM_we_n,
  input  logic [ADDR_W-1:0] VGA_SRAM_address,
  input  logic              M2_done,
  input  logic              M1_done,
  output logic              UART_rx_initialize,
  output logic              UART_rx_enable,
  output logic              M2_start,
  output logic              M1_start,
  output logic              VGA_enable,
  output logic [ADDR_W-1:0] SRAM_address,
  output logic [DATA_W-1:0] SRAM_write_data,
  output logic              SRAM_we_n,
  output logic [PHASE_W-1:0] Phase,
  output logic              Watchdog_error,
  output logic [7:0]        Decode_count
);

  top_state_type state_reg;
  logic          first_cycle_reg;
  logic          uart_init_reg;
  logic          uart_en_reg;
  logic          m2_start_reg;
  logic          m1_start_reg;
  logic          vga_en_reg;
  logic          wdog_err_reg;
  logic [7:0]    decode_count_reg;

  logic in_uart;
  logic in_unit;
  logic uart_tc;
  logic wdog_tc;

  assign in_uart = (state_reg == S_UART_RX);
  assign in_unit = is_unit_phase(state_reg);

  // Any UART write restarts the idle timeout; leaving reception resets it for next time.
  sram_phase_scheduler_phase_timer #(
    .TERMINAL (UART_TIMEOUT - 1)
  ) u_uart_timer (
    .clk    (CLOCK_50_I),
    .srst   (Reset),
    .clear  (!in_uart || !UART_SRAM_we_n),
    .enable (in_uart),
    .tc     (uart_tc)
  );

  sram_phase_scheduler_phase_timer #(
    .TERMINAL (WDOG_CYCLES - 1)
  ) u_wdog_timer (
    .clk    (CLOCK_50_I),
    .srst   (Reset),
    .clear  (!in_unit),
    .enable (in_unit),
    .tc     (wdog_tc)
  );

  always_ff @(posedge CLOCK_50_I) begin
    if (Reset) begin
      state_reg        <= S_IDLE;
      first_cycle_reg  <= 1'b0;
      uart_init_reg    <= 1'b0;
      uart_en_reg      <= 1'b0;
      m2_start_reg     <= 1'b0;
      m1_start_reg     <= 1'b0;
      vga_en_reg       <= 1'b1;
      wdog_err_reg     <= 1'b0;
      decode_count_reg <= 8'd0;
    end else begin
      uart_init_reg   <= 1'b0;
      uart_en_reg     <= uart_init_reg;
      m2_start_reg    <= 1'b0;
      m1_start_reg    <= 1'b0;
      first_cycle_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (!UART_RX_I) begin
            state_reg     <= S_UART_RX;
            uart_init_reg <= 1'b1;
            wdog_err_reg  <= 1'b0;
            vga_en_reg    <= 1'b0;
          end
        end
        S_UART_RX: begin
          if (uart_tc) state_reg <= S_GAP_M2;
        end
        S_GAP_M2: begin
          state_reg       <= S_M2;
          m2_start_reg    <= 1'b1;
          first_cycle_reg <= 1'b1;
        end
        // done wins over a watchdog expiry landing in the same cycle
        S_M2: begin
          if (!first_cycle_reg && M2_done) begin
            state_reg <= S_GAP_M1;
          end else if (wdog_tc) begin
            state_reg    <= S_IDLE;
            wdog_err_reg <= 1'b1;
            vga_en_reg   <= 1'b1;
          end
        end
        S_GAP_M1: begin
          state_reg       <= S_M1;
          m1_start_reg    <= 1'b1;
          first_cycle_reg <= 1'b1;
        end
        S_M1: begin
          if (!first_cycle_reg && M1_done) begin
            state_reg        <= S_IDLE;
            decode_count_reg <= decode_count_reg + 8'd1;
            vga_en_reg       <= 1'b1;
          end else if (wdog_tc) begin
            state_reg    <= S_IDLE;
            wdog_err_reg <= 1'b1;
            vga_en_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg  <= S_IDLE;
          vga_en_reg <= 1'b1;
        end
      endcase
    end
  end

  // Only the granted requester reaches the SRAM; gaps and IDLE can never write.
  always_comb begin
    SRAM_address    = '0;
    SRAM_write_data = '0;
    SRAM_we_n       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        SRAM_address = VGA_SRAM_address;
      end
      S_UART_RX: begin
        SRAM_address    = UART_SRAM_address;
        SRAM_write_data = UART_SRAM_wdata;
        SRAM_we_n       = UART_SRAM_we_n;
      end
      S_M2: begin
        SRAM_address    = M2_SRAM_address;
        SRAM_write_data = M2_SRAM_wdata;
        SRAM_we_n       = M2_SRAM_we_n;
      end
      S_M1: begin
        SRAM_address    = M1_SRAM_address;
        SRAM_write_data = M1_SRAM_wdata;
        SRAM_we_n       = M1_SRAM_we_n;
      end
      default: begin
        SRAM_we_n = 1'b1;
      end
    endcase
  end

  assign UART_rx_initialize = uart_init_reg;
  assign UART_rx_enable     = uart_en_reg;
  assign M2_start           = m2_start_reg;
  assign M1_start           = m1_start_reg;
  assign VGA_enable         = vga_en_reg;
  assign Phase              = state_reg;
  assign Watchdog_error     = wdog_err_reg;
  assign Decode_count       = decode_count_reg;

endmodule
